// File: rtl/pcpi_dispatch.sv
// rtl/pcpi_dispatch.sv - PCPI issue stage: request/response handshake around one coprocessor op.
// Optional unclaimed-instruction watchdog enabled by defining PCPI_DISPATCH_TIMEOUT_EN.
module pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t      r_state, w_state_n;
    logic        r_req_ready, w_req_ready_n;
    logic        r_rsp_valid, w_rsp_valid_n;
    logic        r_rsp_wr, w_rsp_wr_n;
    logic [31:0] r_rsp_rd, w_rsp_rd_n;
    logic        r_rsp_trap, w_rsp_trap_n;
    logic        r_pcpi_valid, w_pcpi_valid_n;
    logic [31:0] r_insn, w_insn_n;
    logic [31:0] r_rs1, w_rs1_n;
    logic [31:0] r_rs2, w_rs2_n;

`ifdef PCPI_DISPATCH_TIMEOUT_EN
    logic [7:0]  r_cnt, w_cnt_n;
    logic        r_claimed, w_claimed_n;
    logic        w_claimed;

    // A wait seen this cycle counts as claimed, so expiry never fires on the claiming cycle.
    assign w_claimed = r_claimed | pcpi_wait;
`else
    logic        w_unused_wait;
    assign w_unused_wait = pcpi_wait;
`endif

    always_comb begin
        w_state_n      = r_state;
        w_req_ready_n  = r_req_ready;
        w_rsp_valid_n  = r_rsp_valid;
        w_rsp_wr_n     = r_rsp_wr;
        w_rsp_rd_n     = r_rsp_rd;
        w_rsp_trap_n   = r_rsp_trap;
        w_pcpi_valid_n = r_pcpi_valid;
        w_insn_n       = r_insn;
        w_rs1_n        = r_rs1;
        w_rs2_n        = r_rs2;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
        w_cnt_n        = r_cnt;
        w_claimed_n    = r_claimed;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_insn_n       = req_insn;
                    w_rs1_n        = req_rs1;
                    w_rs2_n        = req_rs2;
                    w_pcpi_valid_n = 1'b1;
                    w_req_ready_n  = 1'b0;
                    w_state_n      = S_BUSY;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
                    w_cnt_n        = 8'd0;
                    w_claimed_n    = 1'b0;
`endif
                end
            end
            S_BUSY: begin
                if (pcpi_ready) begin
                    w_rsp_wr_n     = pcpi_wr;
                    w_rsp_rd_n     = pcpi_rd;
                    w_rsp_trap_n   = 1'b0;
                    w_pcpi_valid_n = 1'b0;
                    w_rsp_valid_n  = 1'b1;
                    w_state_n      = S_RESP;
                end
`ifdef PCPI_DISPATCH_TIMEOUT_EN
                else if (!w_claimed && (r_cnt == 8'(TIMEOUT_CYCLES - 1))) begin
                    w_rsp_wr_n     = 1'b0;
                    w_rsp_rd_n     = 32'd0;
                    w_rsp_trap_n   = 1'b1;
                    w_pcpi_valid_n = 1'b0;
                    w_rsp_valid_n  = 1'b1;
                    w_state_n      = S_RESP;
                end else begin
                    w_claimed_n = w_claimed;
                    if (!w_claimed) begin
                        w_cnt_n = r_cnt + 8'd1;
                    end
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_n = 1'b0;
                    w_req_ready_n = 1'b1;
                    w_state_n     = S_IDLE;
                end
            end
            default: begin
                w_state_n      = S_IDLE;
                w_req_ready_n  = 1'b1;
                w_rsp_valid_n  = 1'b0;
                w_pcpi_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_wr     <= 1'b0;
            r_rsp_rd     <= 32'd0;
            r_rsp_trap   <= 1'b0;
            r_pcpi_valid <= 1'b0;
            r_insn       <= 32'd0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
            r_cnt        <= 8'd0;
            r_claimed    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_req_ready  <= w_req_ready_n;
            r_rsp_valid  <= w_rsp_valid_n;
            r_rsp_wr     <= w_rsp_wr_n;
            r_rsp_rd     <= w_rsp_rd_n;
            r_rsp_trap   <= w_rsp_trap_n;
            r_pcpi_valid <= w_pcpi_valid_n;
            r_insn       <= w_insn_n;
            r_rs1        <= w_rs1_n;
            r_rs2        <= w_rs2_n;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
            r_cnt        <= w_cnt_n;
            r_claimed    <= w_claimed_n;
`endif
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_rd     = r_rsp_rd;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
    assign rsp_trap   = r_rsp_trap;
`else
    // Trap can never be set without the watchdog; keep the port a constant.
    assign rsp_trap   = 1'b0;
`endif
    assign pcpi_valid = r_pcpi_valid;
    assign pcpi_insn  = r_insn;
    assign pcpi_rs1   = r_rs1;
    assign pcpi_rs2   = r_rs2;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// tb/tb_pcpi_dispatch.sv - directed self-checking bench for pcpi_dispatch.
module tb_pcpi_dispatch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn, req_rs1, req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_trap;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pcpi_dispatch #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_trap(rsp_trap),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {7'b0000001, 10'd0, f3, 5'd1, 7'b0110011};
    endfunction

    function automatic logic [31:0] mul_model(input logic [31:0] insn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        case (insn[14:12])
            3'b000:  p = {32'd0, a} * {32'd0, b};
            3'b001:  p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'b010:  p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (insn[14:12] == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    // Issue one request, act as the multiplier with given latency, stop on the ready edge.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        logic [31:0] insn;
        insn      = mk_insn(f3);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = a;
        req_rs2   = b;
        step();
        req_valid = 1'b0;
        req_insn  = 32'hDEAD_BEEF;
        chk("pcpi_valid_rise", {31'd0, pcpi_valid}, 32'd1);
        chk("pcpi_rs1", pcpi_rs1, a);
        chk("pcpi_rs2", pcpi_rs2, b);
        for (int i = 1; i < lat; i++) begin
            step();
            chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
            chk("busy_insn_stable", pcpi_insn, insn);
        end
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = mul_model(insn, a, b);
        step();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'h5555_AAAA;
        chk("pcpi_valid_drop", {31'd0, pcpi_valid}, 32'd0);
        chk("rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        rsp_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'd0);
        chk("rst_pcpi_insn", pcpi_insn, 32'd0);
        resetn = 1'b1;
        step();

        // MUL 3*7
        run_op(3'b000, 32'd3, 32'd7, 3);
        chk("mul_wr", {31'd0, rsp_wr}, 32'd1);
        chk("mul_rd", rsp_rd, 32'd21);
        chk("mul_trap", {31'd0, rsp_trap}, 32'd0);
        step();
        chk("mul_consumed", {31'd0, rsp_valid}, 32'd0);
        chk("mul_req_ready_back", {31'd0, req_ready}, 32'd1);

        // MULHU then back-to-back MULH
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        chk("mulhu_rd", rsp_rd, 32'hFFFF_FFFE);
        step();
        chk("mulhu_req_ready_back", {31'd0, req_ready}, 32'd1);
        run_op(3'b001, 32'hFFFF_FFF6, 32'hFFFF_FFFC, 2);
        chk("mulh_rd", rsp_rd, 32'd0);
        chk("mulh_wr", {31'd0, rsp_wr}, 32'd1);
        step();
        chk("mulh_consumed", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: five cycles held, consumed on the sixth
        rsp_ready = 1'b0;
        run_op(3'b000, 32'd1000, 32'd1000, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rd", rsp_rd, 32'd1000000);
            chk("bp_trap", {31'd0, rsp_trap}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            if (i < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_consumed", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("bp_req_ready_back", {31'd0, req_ready}, 32'd1);

        // Claimed at cycle 2, answered at cycle 40: never traps
        req_valid = 1'b1; req_insn = mk_insn(3'b000); req_rs1 = 32'd5; req_rs2 = 32'd6;
        step();
        req_valid = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (i >= 2) pcpi_wait = 1'b1;
            step();
            if (rsp_valid) begin
                chk("wait_early_rsp", {31'd0, rsp_valid}, 32'd0);
                break;
            end
        end
        pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h1234;
        step();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wait_trap", {31'd0, rsp_trap}, 32'd0);
        chk("wait_rd", rsp_rd, 32'h1234);
        step();
        chk("wait_consumed", {31'd0, rsp_valid}, 32'd0);

`ifdef PCPI_DISPATCH_TIMEOUT_EN
        // Nobody claims: trap exactly 16 cycles after pcpi_valid rose
        req_valid = 1'b1; req_insn = mk_insn(3'b000); req_rs1 = 32'd9; req_rs2 = 32'd9;
        step();
        req_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_not_yet", {31'd0, rsp_valid}, 32'd0);
        end
        step();
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_trap", {31'd0, rsp_trap}, 32'd1);
        chk("to_wr", {31'd0, rsp_wr}, 32'd0);
        chk("to_rd", rsp_rd, 32'd0);
        chk("to_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        step();
        chk("to_consumed", {31'd0, rsp_valid}, 32'd0);
`endif

        // Reset while BUSY, then a stale ready from the aborted op
        req_valid = 1'b1; req_insn = mk_insn(3'b000); req_rs1 = 32'd2; req_rs2 = 32'd2;
        step();
        req_valid = 1'b0;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("rstmid_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        step();
        step();
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hBAD0_0001;
        step();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("rstmid_no_rsp2", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_idle", {31'd0, req_ready}, 32'd1);

        // Stray ready in IDLE
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hBAD0_0002;
        step();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        step();
        chk("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("stray_idle", {31'd0, req_ready}, 32'd1);
        chk("stray_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcpi_dispatch.md
Name: pcpi_dispatch

Overview:
- Issue stage sitting directly upstream of the PCPI multiply coprocessor.
- Accepts a decoded instruction plus operands from the core over a valid/ready request channel and drives the PCPI bus (pcpi_valid/insn/rs1/rs2).
- Holds the request until the coprocessor answers, then returns the result (wr/rd) over a valid/ready response channel.
- Optional watchdog flags instructions that no coprocessor claims.

Parameters:
- TIMEOUT_CYCLES, 16, cycles pcpi_valid may stay high with neither pcpi_wait nor pcpi_ready before a trap is raised (range 2..255).

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  dispatcher can accept a request
- req_insn  in  32  instruction word
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_wr  out  1  result must be written to rd
- rsp_rd  out  32  result value
- rsp_trap  out  1  no coprocessor claimed the instruction
- pcpi_valid  out  1  PCPI request strobe
- pcpi_insn  out  32  latched instruction
- pcpi_rs1  out  32  latched operand 1
- pcpi_rs2  out  32  latched operand 2
- pcpi_wr  in  1  coprocessor write-enable
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor has claimed the instruction and is busy
- pcpi_ready  in  1  coprocessor result valid (single-cycle pulse)

Behaviour:
- Reset values (clk edge with resetn=0): state IDLE; req_ready=1; rsp_valid=0; rsp_wr=0; rsp_rd=0; rsp_trap=0; pcpi_valid=0; pcpi_insn/rs1/rs2=0; timeout counter=0; claimed flag=0.
- State machine: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch insn/rs1/rs2 onto the pcpi_* outputs, set pcpi_valid=1, clear counter and claimed flag, go BUSY.
  - pcpi_valid is high from the cycle after acceptance.
- BUSY:
  - req_ready=0; pcpi_valid and pcpi_* operands held stable.
  - Each cycle, pcpi_wait=1 sets the claimed flag.
  - On sampled pcpi_ready=1: capture rsp_wr=pcpi_wr, rsp_rd=pcpi_rd, rsp_trap=0; clear pcpi_valid; set rsp_valid=1; go RESP.
  - pcpi_valid is therefore low the cycle after ready, so the coprocessor never sees a second launch.
- RESP:
  - rsp_valid=1; rsp_wr/rd/trap held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: clear rsp_valid, go IDLE.
  - If rsp_ready is already high when rsp_valid rises, the handshake completes that edge.
  - req_ready returns 1 the following cycle. There is no same-cycle response/request overlap; the minimum turnaround is 1 idle cycle.
- Latency: a request accepted at edge N, with the coprocessor pulsing pcpi_ready sampled at edge M, produces rsp_valid high after edge M. The dispatcher adds 0 cycles on top of coprocessor latency, plus 1 cycle in RESP.
- pcpi_ready, pcpi_wait, pcpi_wr and pcpi_rd are ignored in IDLE and RESP. A stray ready pulse must not alter the response.
- pcpi_rd is captured only when pcpi_ready=1. When pcpi_wr=0, rsp_rd still carries the captured pcpi_rd value.
- Reset mid-operation: synchronous reset wins over every transition. pcpi_valid drops at that edge, and a later pcpi_ready from the aborted operation is ignored (state IDLE).
- req_valid is sampled only in IDLE. Request fields may change freely at all other times.

Optional Feature:
- Macro: PCPI_DISPATCH_TIMEOUT_EN.
- Defined:
  - In BUSY, the counter increments each cycle while the claimed flag is 0 and pcpi_ready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 and the instruction is still unclaimed: rsp_trap=1, rsp_wr=0, rsp_rd=0, pcpi_valid cleared, go RESP.
  - pcpi_ready sampled in the same cycle as expiry wins (normal result, trap=0).
  - Once pcpi_wait has been seen, the counter stops and the dispatcher waits indefinitely.
- Undefined:
  - No counter logic exists and rsp_trap is tied to 0.
  - BUSY exits only on pcpi_ready.

Test Plan:
- MUL: insn funct3=000, rs1=3, rs2=7, with the multiplier attached and rsp_ready=1 -> one response: rsp_wr=1, rsp_rd=21, rsp_trap=0; pcpi_valid low the cycle after pcpi_ready.
- MULHU: rs1=32'hFFFFFFFF, rs2=32'hFFFFFFFF, funct3=011 -> rsp_rd=32'hFFFFFFFE. Then a back-to-back MULH with rs1=-10, rs2=-4 -> rsp_rd=0; req_ready low throughout both BUSY phases.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rd and rsp_trap stable for all 5 cycles and req_ready=0; the response is consumed on the 6th cycle with rsp_ready=1.
- With PCPI_DISPATCH_TIMEOUT_EN and a stub that never responds -> rsp_valid with rsp_trap=1, rsp_wr=0, rsp_rd=0 exactly TIMEOUT_CYCLES (16) cycles after pcpi_valid rose. Stub asserting pcpi_wait at cycle 2 and pcpi_ready at cycle 40 with rd=32'h1234 -> rsp_trap=0, rsp_rd=32'h1234.
- Reset mid-operation: assert resetn=0 for 1 cycle while in BUSY -> pcpi_valid=0 and req_ready=1 after that edge. A pcpi_ready pulse 3 cycles later produces no rsp_valid.
- Stray pcpi_ready pulse while in IDLE -> rsp_valid stays 0 and the state remains IDLE.
